// File: rtl/data_mem_ctrl_if.sv
// Host/processor-facing signal bundle of the data-memory controller.
// master = host + processor side, slave = controller.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int BUS_W  = 17
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              proc_run;
    logic              dm_en;
    logic [ADDR_W-1:0] proc_addr;
    logic [BUS_W-1:0]  proc_wdata;
    logic              end_process;
    logic [DATA_W-1:0] dm_out;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              dump_ready;

    modport master (
        output ld_valid, ld_data, ld_last, dm_en, proc_addr, proc_wdata,
               end_process, dump_ready,
        input  ld_ready, proc_run, dm_out, dump_valid, dump_data, dump_last
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, dm_en, proc_addr, proc_wdata,
               end_process, dump_ready,
        output ld_ready, proc_run, dm_out, dump_valid, dump_data, dump_last
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: host preload, processor run, result dump.
// Define DMC_RD_FWD_EN for write-first reads on the processor port.
module data_mem_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 12,
    parameter int BUS_W     = 17,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 16
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_LOAD, S_RUN, S_DRAIN, S_DUMP, S_DONE} state_t;

    localparam int                 DEPTH  = 1 << ADDR_W;
    localparam int                 CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]  BASE   = ADDR_W'(DUMP_BASE);
    localparam logic [CNT_W-1:0]   LAST_K = CNT_W'(DUMP_LEN - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [ADDR_W-1:0] dump_ptr_q, dump_ptr_d;
    logic [CNT_W-1:0]  dump_cnt_q, dump_cnt_d;
    logic              ld_ready_q, ld_ready_d;
    logic              proc_run_q, proc_run_d;
    logic [DATA_W-1:0] dm_out_q, dm_out_d;
    logic              dump_valid_q, dump_valid_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              dump_last_q, dump_last_d;

    logic              ld_fire;
    logic              run_wr;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic              unused_wdata;

    assign ld_fire      = ld_ready_q && bus.ld_valid;
    assign run_wr       = (state_q == S_RUN) && bus.dm_en;
    assign wr_word      = bus.proc_wdata[DATA_W-1:0];
    assign unused_wdata = ^bus.proc_wdata;

`ifdef DMC_RD_FWD_EN
    assign rd_word = run_wr ? wr_word : mem[bus.proc_addr];
`else
    assign rd_word = mem[bus.proc_addr];
`endif

    // RAM contents survive reset; only the port owned by the current phase writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_fire) begin
                mem[ld_ptr_q] <= bus.ld_data;
            end else if (run_wr) begin
                mem[bus.proc_addr] <= wr_word;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_ptr_d     = ld_ptr_q;
        dump_ptr_d   = dump_ptr_q;
        dump_cnt_d   = dump_cnt_q;
        ld_ready_d   = ld_ready_q;
        proc_run_d   = proc_run_q;
        dm_out_d     = dm_out_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        dump_last_d  = dump_last_q;
        case (state_q)
            S_LOAD: begin
                if (ld_fire) begin
                    if (bus.ld_last || (ld_ptr_q == '1)) begin
                        state_d    = S_RUN;
                        ld_ready_d = 1'b0;
                        proc_run_d = 1'b1;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                dm_out_d = rd_word;
                if (bus.end_process) begin
                    state_d    = S_DRAIN;
                    proc_run_d = 1'b0;
                end
            end
            S_DRAIN: begin
                state_d    = S_DUMP;
                dump_ptr_d = BASE;
                dump_cnt_d = '0;
            end
            S_DUMP: begin
                // Output register refills whenever empty or being accepted.
                if (dump_valid_q && bus.dump_ready && dump_last_q) begin
                    state_d      = S_DONE;
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                    dump_data_d  = '0;
                end else if (!dump_valid_q || bus.dump_ready) begin
                    dump_valid_d = 1'b1;
                    dump_data_d  = mem[dump_ptr_q];
                    dump_last_d  = (dump_cnt_q == LAST_K);
                    dump_ptr_d   = dump_ptr_q + 1'b1;
                    dump_cnt_d   = dump_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            ld_ptr_q     <= '0;
            dump_ptr_q   <= '0;
            dump_cnt_q   <= '0;
            ld_ready_q   <= 1'b1;
            proc_run_q   <= 1'b0;
            dm_out_q     <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            dump_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_ptr_q     <= ld_ptr_d;
            dump_ptr_q   <= dump_ptr_d;
            dump_cnt_q   <= dump_cnt_d;
            ld_ready_q   <= ld_ready_d;
            proc_run_q   <= proc_run_d;
            dm_out_q     <= dm_out_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            dump_last_q  <= dump_last_d;
        end
    end

    assign bus.ld_ready   = ld_ready_q;
    assign bus.proc_run   = proc_run_q;
    assign bus.dm_out     = dm_out_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_last  = dump_last_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with a 16-word window at 0,
// a second with a 4-word window at 4094 exercising load overflow and wrap.
module tb_data_mem_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    data_mem_ctrl_if #(.ADDR_W(12), .DATA_W(12), .BUS_W(17)) b1 ();
    data_mem_ctrl_if #(.ADDR_W(12), .DATA_W(12), .BUS_W(17)) b2 ();

    data_mem_ctrl #(.ADDR_W(12), .DATA_W(12), .BUS_W(17), .DUMP_BASE(0), .DUMP_LEN(16))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    data_mem_ctrl #(.ADDR_W(12), .DATA_W(12), .BUS_W(17), .DUMP_BASE(4094), .DUMP_LEN(4))
        u2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] fill2(input int a);
        logic [11:0] av;
        av = 12'(a);
        return av ^ 12'h5A5;
    endfunction

    logic [11:0] exp_mem [16];
    logic [11:0] dm_hold;
    logic [3:0]  pat;
    logic        r;
    int          k;
    int          cyc;
    int          wa [4];

    initial begin
        clk = 1'b0;
        vectors = 0;
        miscompares = 0;
        pat = 4'b1001;
        wa = '{4094, 4095, 0, 1};
        b1.ld_valid = 0; b1.ld_data = '0; b1.ld_last = 0; b1.dm_en = 0;
        b1.proc_addr = '0; b1.proc_wdata = '0; b1.end_process = 0; b1.dump_ready = 0;
        b2.ld_valid = 0; b2.ld_data = '0; b2.ld_last = 0; b2.dm_en = 0;
        b2.proc_addr = '0; b2.proc_wdata = '0; b2.end_process = 0; b2.dump_ready = 0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ld_ready", b1.ld_ready, 1);
        chk("rst_proc_run", b1.proc_run, 0);
        chk("rst_dm_out", b1.dm_out, 0);
        chk("rst_dump_valid", b1.dump_valid, 0);
        chk("rst_dump_data", b1.dump_data, 0);
        chk("rst_dump_last", b1.dump_last, 0);
        rst = 1'b0;

        // partial load then asynchronous reset
        b1.ld_valid = 1; b1.ld_data = 12'h111; tick();
        b1.ld_data = 12'h222; tick();
        b1.ld_data = 12'h333; tick();
        b1.ld_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("midload_rst_ld_ready", b1.ld_ready, 1);
        chk("midload_rst_proc_run", b1.proc_run, 0);
        chk("midload_rst_dump_valid", b1.dump_valid, 0);
        #2 rst = 1'b0;
        tick();
        b1.ld_valid = 1; b1.ld_data = 12'hAAA; b1.ld_last = 1;
        tick();
        b1.ld_valid = 0; b1.ld_last = 0;
        chk("reload_ld_ready", b1.ld_ready, 0);
        chk("reload_proc_run", b1.proc_run, 1);
        b1.proc_addr = 12'd0;
        tick();
        chk("reload_mem0", b1.dm_out, 12'hAAA);

        // asynchronous reset while running
        #2 rst = 1'b1;
        #1;
        chk("runrst_proc_run", b1.proc_run, 0);
        chk("runrst_ld_ready", b1.ld_ready, 1);
        chk("runrst_dm_out", b1.dm_out, 0);
        #2 rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            b1.ld_valid = 1; b1.ld_data = 12'(i + 1); b1.ld_last = (i == 15);
            exp_mem[i] = 12'(i + 1);
            tick();
        end
        b1.ld_valid = 0; b1.ld_last = 0;
        chk("load16_proc_run", b1.proc_run, 1);
        chk("load16_ld_ready", b1.ld_ready, 0);
        b1.proc_addr = 12'd5;
        tick();
        chk("read_addr5", b1.dm_out, 12'h006);

        // write/read hazard at a held address
        b1.dm_en = 1; b1.proc_wdata = 17'h10ABC;
        tick();
        b1.dm_en = 0;
`ifdef DMC_RD_FWD_EN
        chk("hazard_same_cycle", b1.dm_out, 12'hABC);
`else
        chk("hazard_same_cycle", b1.dm_out, 12'h006);
`endif
        tick();
        chk("hazard_next_cycle", b1.dm_out, 12'hABC);
        exp_mem[5] = 12'hABC;

        // stray host beats outside LOAD must be ignored
        b1.ld_valid = 1; b1.ld_data = 12'h555;

        // end_process with a same-cycle write that must commit
        b1.proc_addr = 12'd7; b1.dm_en = 1; b1.proc_wdata = 17'h01F77; b1.end_process = 1;
        tick();
        exp_mem[7] = 12'hF77;
`ifdef DMC_RD_FWD_EN
        dm_hold = 12'hF77;
`else
        dm_hold = 12'h008;
`endif
        b1.end_process = 0; b1.proc_addr = 12'd0; b1.proc_wdata = 17'h00000;
        chk("end_proc_run", b1.proc_run, 0);
        chk("end_dm_out", b1.dm_out, dm_hold);
        chk("end_dump_valid", b1.dump_valid, 0);
        chk("end_ld_ready", b1.ld_ready, 0);
        tick();
        chk("drain_dump_valid", b1.dump_valid, 0);
        b1.dump_ready = 0;
        tick();

        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            chk($sformatf("dump_valid_k%0d", k), b1.dump_valid, 1);
            chk($sformatf("dump_data_k%0d", k), b1.dump_data, exp_mem[k]);
            chk($sformatf("dump_last_k%0d", k), b1.dump_last, (k == 15));
            chk("dump_dm_out_hold", b1.dm_out, dm_hold);
            r = pat[cyc % 4];
            b1.dump_ready = r;
            tick();
            if (r) k++;
            cyc++;
        end
        chk("dump_beats", k, 16);
        chk("done_dump_valid", b1.dump_valid, 0);
        chk("done_dump_last", b1.dump_last, 0);
        chk("done_proc_run", b1.proc_run, 0);
        tick();
        chk("done_sticky_valid", b1.dump_valid, 0);
        chk("done_sticky_ld_ready", b1.ld_ready, 0);
        b1.ld_valid = 0; b1.dm_en = 0; b1.dump_ready = 0;

        // second instance: 4096 beats without ld_last, then a wrapping dump
        for (int i = 0; i < 4095; i++) begin
            b2.ld_valid = 1; b2.ld_data = fill2(i); b2.ld_last = 0;
            tick();
        end
        chk("ovf_before_ld_ready", b2.ld_ready, 1);
        chk("ovf_before_proc_run", b2.proc_run, 0);
        b2.ld_data = fill2(4095);
        tick();
        b2.ld_valid = 0;
        chk("ovf_ld_ready", b2.ld_ready, 0);
        chk("ovf_proc_run", b2.proc_run, 1);
        b2.end_process = 1;
        tick();
        b2.end_process = 0;
        b2.dump_ready = 1;
        tick();
        tick();
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("wrap_valid_%0d", j), b2.dump_valid, 1);
            chk($sformatf("wrap_data_%0d", j), b2.dump_data, fill2(wa[j]));
            chk($sformatf("wrap_last_%0d", j), b2.dump_last, (j == 3));
            tick();
        end
        chk("wrap_done_valid", b2.dump_valid, 0);
        b2.dump_ready = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
